// File: rtl/mio_bus_responder_if.sv
// CPU-side memory port of the bus responder: request, address, data and the
// one-cycle completion pulse that gates the CPU's PC/IR update.
interface mio_bus_responder_if;
  logic        req;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] data_from_cpu;
  logic [31:0] data2CPU;
  logic        MIO_ready;

  modport master (
    output req, mem_w, addr, data_from_cpu,
    input  data2CPU, MIO_ready
  );

  modport slave (
    input  req, mem_w, addr, data_from_cpu,
    output data2CPU, MIO_ready
  );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes CPU word requests onto a wait-stated RAM,
// a GPIO block (LED/switches) and a free-running 32-bit timer.
module mio_bus_responder #(
  parameter int RAM_AW   = 12,
  parameter int RAM_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  mio_bus_responder_if.slave  bus,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_din,
  output logic                ram_we,
  input  logic [31:0]         ram_dout,
  input  logic [15:0]         sw,
  output logic [15:0]         led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_GPIO = 4'hE;
  localparam logic [3:0] REGION_TMR  = 4'hF;
  localparam logic [3:0] WAIT_LOAD   = 4'(RAM_WAIT - 1);

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic                wr_q, wr_d;
  logic                ready_q, ready_d;
  logic [31:0]         d2c_q, d2c_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_din_q, ram_din_d;
  logic                ram_we_q, ram_we_d;
  logic [15:0]         led_q, led_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                run_q, run_d;

  logic [3:0]          region_s;
  logic [31:0]         periph_rdata_s;
  logic                unused_s;

  assign region_s = bus.addr[31:28];
  assign unused_s = ^{bus.addr[27:RAM_AW+2], bus.addr[1:0]};

  // Peripheral read mux, sampled in the acceptance cycle
  always_comb begin
    periph_rdata_s = 32'd0;
    case (region_s)
      REGION_GPIO: begin
        if (bus.addr[2]) begin
          periph_rdata_s = {16'd0, sw};
        end else begin
          periph_rdata_s = {16'd0, led_q};
        end
      end
      REGION_TMR: begin
        if (bus.addr[2]) begin
          periph_rdata_s = {31'd0, run_q};
        end else begin
          periph_rdata_s = cnt_q;
        end
      end
      default: periph_rdata_s = 32'd0;
    endcase
  end

  // Next-state logic for the access FSM, peripherals and timer
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    wr_d       = wr_q;
    d2c_d      = d2c_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = ram_we_q;
    led_d      = led_q;
    run_d      = run_q;
    // A CPU load of the count overrides this increment further down
    cnt_d      = run_q ? (cnt_q + 32'd1) : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (region_s == REGION_RAM) begin
            state_d    = S_WAIT;
            wait_d     = WAIT_LOAD;
            wr_d       = bus.mem_w;
            ram_addr_d = bus.addr[RAM_AW+1:2];
            ram_din_d  = bus.data_from_cpu;
            ram_we_d   = bus.mem_w;
          end else begin
            state_d = S_DONE;
            wr_d    = bus.mem_w;
            if (bus.mem_w) begin
              case (region_s)
                REGION_GPIO: begin
                  if (!bus.addr[2]) begin
                    led_d = bus.data_from_cpu[15:0];
                  end else begin
                    led_d = led_q;
                  end
                end
                REGION_TMR: begin
                  if (bus.addr[2]) begin
                    run_d = bus.data_from_cpu[0];
                  end else begin
                    cnt_d = bus.data_from_cpu;
                  end
                end
                default: led_d = led_q;
              endcase
            end else begin
              d2c_d = periph_rdata_s;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        ram_we_d = 1'b0;
        if (wait_q == 4'd0) begin
          state_d = S_DONE;
          if (!wr_q) begin
            d2c_d = ram_dout;
          end else begin
            d2c_d = d2c_q;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      d2c_q      <= 32'd0;
      ram_addr_q <= '0;
      ram_din_q  <= 32'd0;
      ram_we_q   <= 1'b0;
      led_q      <= 16'd0;
      cnt_q      <= 32'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      d2c_q      <= d2c_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
    end
  end

  assign bus.MIO_ready = ready_q;
  assign bus.data2CPU  = d2c_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign ram_we        = ram_we_q;
  assign led           = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench: transaction-level model of the responder checked every cycle, plus
// literal expectations and a RAM_WAIT=1 back-to-back build.
module tb_mio_bus_responder;
  localparam int RAM_AW   = 12;
  localparam int RAM_WAIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  mio_bus_responder_if bus_a ();
  mio_bus_responder_if bus_b ();

  logic [RAM_AW-1:0] ram_addr_a, ram_addr_b;
  logic [31:0]       ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic              ram_we_a, ram_we_b;
  logic [15:0]       sw, led_a, led_b;

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
    .ram_dout(ram_dout_a), .sw(sw), .led(led_a)
  );

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
    .ram_dout(ram_dout_b), .sw(sw), .led(led_b)
  );

  function automatic logic [31:0] init_val(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Board RAM for the main DUT; read-only pattern RAM for the second
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  assign ram_dout_a = mem[ram_addr_a];
  assign ram_dout_b = init_val(int'(ram_addr_b));
  always @(posedge clk) if (ram_we_a) mem[ram_addr_a] <= ram_din_a;

  // Reference model state
  logic [31:0] exp_mem [0:(1<<RAM_AW)-1];
  int          exp_rdy_cyc = -1;
  int          exp_we_cyc  = -1;
  logic [31:0] exp_we_addr, exp_we_data;
  logic [31:0] d2c_cur = 32'd0, d2c_next = 32'd0;
  int          d2c_sw = 0;
  logic [15:0] led_cur = 16'd0, led_next = 16'd0;
  int          led_sw = 0;
  logic [31:0] tmr_base = 32'd0;
  int          tmr_cyc = 0;
  bit          tmr_run = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] tmr_val(int c);
    return tmr_run ? tmr_base + 32'(c - tmr_cyc) : tmr_base;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, bus_a.MIO_ready}, {31'd0, (cyc == exp_rdy_cyc)});
      chk("data2CPU", bus_a.data2CPU, (cyc >= d2c_sw) ? d2c_next : d2c_cur);
      chk("led", {16'd0, led_a}, {16'd0, (cyc >= led_sw) ? led_next : led_cur});
      chk("ram_we", {31'd0, ram_we_a}, {31'd0, (cyc == exp_we_cyc)});
      if (cyc == exp_we_cyc) begin
        chk("ram_waddr", {20'd0, ram_addr_a}, exp_we_addr);
        chk("ram_wdata", ram_din_a, exp_we_data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One CPU access; called 1 time unit after a rising edge with the DUT idle
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    int acc;
    bit is_ram;
    bit got;
    acc = cyc;
    d2c_cur = d2c_next;
    led_cur = led_next;
    is_ram = (a[31:28] == 4'h0);
    exp_rdy_cyc = acc + (is_ram ? RAM_WAIT + 1 : 1);
    d2c_sw = exp_rdy_cyc;
    led_sw = acc + 1;
    if (w) begin
      if (is_ram) begin
        exp_mem[a[RAM_AW+1:2]] = wd;
        exp_we_cyc  = acc + 1;
        exp_we_addr = {20'd0, a[RAM_AW+1:2]};
        exp_we_data = wd;
      end else if (a[31:28] == 4'hE && !a[2]) begin
        led_next = wd[15:0];
      end else if (a[31:28] == 4'hF) begin
        if (!a[2]) begin
          tmr_base = wd;
          tmr_cyc  = acc + 1;
        end else begin
          tmr_base = tmr_val(acc + 1);
          tmr_cyc  = acc + 1;
          tmr_run  = wd[0];
        end
      end
    end else begin
      case (a[31:28])
        4'h0:    d2c_next = exp_mem[a[RAM_AW+1:2]];
        4'hE:    d2c_next = a[2] ? {16'd0, sw} : {16'd0, led_cur};
        4'hF:    d2c_next = a[2] ? {31'd0, tmr_run} : tmr_val(acc);
        default: d2c_next = 32'd0;
      endcase
    end
    bus_a.req = 1'b1;
    bus_a.mem_w = w;
    bus_a.addr = a;
    bus_a.data_from_cpu = wd;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus_a.MIO_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: no MIO_ready for addr %h, expected at cyc %0d", a, exp_rdy_cyc);
    end
    rd = bus_a.data2CPU;
    @(posedge clk);
    #1;
    bus_a.req = 1'b0;
  endtask

  logic [31:0] rd;
  int bb_cnt = 0;
  int bb_last = -1;
  bit bb_prev = 1'b0;
  bit bb_en = 1'b0;

  // Back-to-back completions on the RAM_WAIT=1 build
  always @(negedge clk) begin
    if (bb_en) begin
      if (bus_b.MIO_ready) begin
        if (bb_last >= 0) chk("bb_spacing", 32'(cyc - bb_last), 32'd3);
        chk("bb_data", bus_b.data2CPU, 32'hC0DE_0008);
        chk("bb_back2back", {31'd0, bb_prev}, 32'd0);
        bb_last = cyc;
        bb_cnt++;
      end
      bb_prev = bus_b.MIO_ready;
    end
  end

  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      mem[i] = init_val(i);
      exp_mem[i] = init_val(i);
    end
    bus_a.req = 1'b0; bus_a.mem_w = 1'b0; bus_a.addr = 32'd0; bus_a.data_from_cpu = 32'd0;
    bus_b.req = 1'b0; bus_b.mem_w = 1'b0; bus_b.addr = 32'h0000_0020; bus_b.data_from_cpu = 32'd0;
    sw = 16'h0000;
    idle(3);
    reset = 1'b0;
    chk("rst_ready", {31'd0, bus_a.MIO_ready}, 32'd0);
    chk("rst_data2CPU", bus_a.data2CPU, 32'd0);
    chk("rst_led", {16'd0, led_a}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we_a}, 32'd0);
    chk("rst_ram_addr", {20'd0, ram_addr_a}, 32'd0);
    chk_en = 1'b1;

    // RAM write then read back
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd);
    access(1'b0, 32'h0000_0010, 32'd0, rd);
    chk("ram_read", rd, 32'hDEAD_BEEF);

    // GPIO
    access(1'b1, 32'hE000_0000, 32'h0000_A5A5, rd);
    chk("led_write", {16'd0, led_a}, 32'h0000_A5A5);
    sw = 16'h1234;
    access(1'b0, 32'hE000_0004, 32'd0, rd);
    chk("sw_read", rd, 32'h0000_1234);
    access(1'b0, 32'hE000_0000, 32'd0, rd);
    chk("led_read", rd, 32'h0000_A5A5);

    // Timer wrap and load-over-increment
    access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, rd);
    access(1'b1, 32'hF000_0004, 32'h0000_0001, rd);
    idle(5);
    access(1'b0, 32'hF000_0000, 32'd0, rd);
    chk("timer_wrap", rd, 32'h0000_0004);
    access(1'b1, 32'hF000_0000, 32'h0000_0100, rd);
    access(1'b0, 32'hF000_0000, 32'd0, rd);
    chk("timer_load", rd, 32'h0000_0101);
    access(1'b0, 32'hF000_0004, 32'd0, rd);
    chk("timer_ctrl", rd, 32'h0000_0001);
    access(1'b1, 32'hF000_0004, 32'h0000_0000, rd);

    // Unmapped region
    access(1'b0, 32'h5000_0000, 32'd0, rd);
    chk("unmapped_read", rd, 32'h0000_0000);
    access(1'b1, 32'h5000_0000, 32'hFFFF_FFFF, rd);
    access(1'b0, 32'h0000_0000, 32'd0, rd);
    chk("unmapped_no_ram", rd, 32'hC0DE_0000);
    chk("unmapped_no_led", {16'd0, led_a}, 32'h0000_A5A5);

    // Reset in cycle 2 of a RAM read
    begin
      int acc;
      acc = cyc;
      d2c_cur = d2c_next; d2c_next = 32'd0; d2c_sw = acc + 3;
      led_cur = led_next; led_next = 16'd0; led_sw = acc + 3;
      exp_rdy_cyc = -1;
      tmr_base = 32'd0; tmr_cyc = acc + 3; tmr_run = 1'b0;
      bus_a.req = 1'b1; bus_a.mem_w = 1'b0; bus_a.addr = 32'h0000_0010;
      idle(2);
      reset = 1'b1;
      bus_a.req = 1'b0;
      idle(1);
      chk("midrst_ready", {31'd0, bus_a.MIO_ready}, 32'd0);
      chk("midrst_data2CPU", bus_a.data2CPU, 32'd0);
      chk("midrst_led", {16'd0, led_a}, 32'd0);
      chk("midrst_ram_addr", {20'd0, ram_addr_a}, 32'd0);
      chk("midrst_ram_din", ram_din_a, 32'd0);
      reset = 1'b0;
      idle(2);
    end
    access(1'b0, 32'h0000_0010, 32'd0, rd);
    chk("reissue_read", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'hF000_0000, 32'd0, rd);
    chk("timer_after_reset", rd, 32'h0000_0000);

    // RAM_WAIT=1 build with req held high
    bb_en = 1'b1;
    bus_b.req = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    bus_b.req = 1'b0;
    bb_en = 1'b0;
    chk("bb_count", 32'(bb_cnt), 32'd10);
    chk("bb_no_write", {31'd0, ram_we_b}, 32'd0);
    chk("bb_din", ram_din_b, 32'd0);
    chk("bb_led", {16'd0, led_b}, 32'd0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder at the far end of the multi-cycle CPU datapath's memory port. It accepts word requests (address, write data, read/write), decodes them onto a wait-stated synchronous RAM, a GPIO register block and a 32-bit timer, and returns read data with a one-cycle `MIO_ready` completion pulse that gates the CPU's PC/IR update. It sits between the CPU core and the board-level RAM and peripherals.

## Interface
- `RAM_AW`, 12: RAM word-address width.
- `RAM_WAIT`, 2: RAM wait cycles per access (legal range 1..15).
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: CPU access request; held stable with `mem_w`/`addr`/`data_from_cpu` until `MIO_ready` cycle.
- `mem_w` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address (CPU `M_addr`); `addr[1:0]` ignored.
- `data_from_cpu` in 32: write data.
- `data2CPU` out 32: read data, valid in `MIO_ready` cycle, held until next completion.
- `MIO_ready` out 1: one-cycle completion pulse.
- `ram_addr` out RAM_AW: RAM word address.
- `ram_din` out 32: RAM write data.
- `ram_we` out 1: RAM write strobe.
- `ram_dout` in 32: RAM read data.
- `sw` in 16: switch inputs.
- `led` out 16: LED register.

## Operation
- Address map by `addr[31:28]`: 0x0 RAM (word `addr[RAM_AW+1:2]`); 0xE GPIO (`addr[2]`=0 LED reg RW, `addr[2]`=1 `{16'b0,sw}` RO); 0xF timer (`addr[2]`=0 count RW, `addr[2]`=1 ctrl RW, bit 0 = run, other bits read 0). Anything else unmapped: read returns 0, write ignored, still completes.
- FSM states IDLE, WAIT, DONE.
  - IDLE & `req` & RAM region -> WAIT, wait counter loaded RAM_WAIT-1; request captured into `ram_addr`/`ram_din`, `ram_we` = `mem_w`.
  - IDLE & `req` & non-RAM -> DONE; peripheral write performed, or read data (values at acceptance cycle) captured into `data2CPU`, on that edge.
  - WAIT: `ram_we` forced 0 after first WAIT cycle; counter==0 -> DONE, capturing `ram_dout` into `data2CPU` on reads; else decrement.
  - DONE: `MIO_ready`=1; unconditionally -> IDLE.
- Writes leave `data2CPU` unchanged.
- Timer: when run=1, count increments by 1 every clock, wrapping 0xFFFFFFFF -> 0. A CPU write to count loads the written value; the load has priority over the increment in that cycle.
- RAM contract: `ram_dout` valid for the captured `ram_addr` by the last WAIT cycle.

## Timing
- Reset (any state, including mid-access): state IDLE, `MIO_ready`=0, `data2CPU`=0, `led`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, timer count=0, ctrl=0. The pending request is dropped and the CPU re-issues it.
- Cycle 0 is the first cycle `req`=1 in IDLE.
  - Peripheral/unmapped: `MIO_ready` in cycle 1.
  - RAM: WAIT for cycles 1..RAM_WAIT, `ram_we` high only in cycle 1 for writes, `MIO_ready` in cycle RAM_WAIT+1 (cycle 3 at default).
- `req` is ignored in WAIT and DONE. The earliest next acceptance is the cycle after DONE, so back-to-back accesses cost one IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then write 0x0000_0010 <- 0xDEADBEEF, then read 0x0000_0010 -> `ram_we` pulsed once in cycle 1 with `ram_addr`=4; read `MIO_ready` in cycle 3 with `data2CPU`=0xDEADBEEF.
- Write 0xE000_0000 <- 0x0000_A5A5 -> `led`=0xA5A5 from cycle 1, `MIO_ready` in cycle 1. Read 0xE000_0004 with `sw`=0x1234 -> `data2CPU`=0x0000_1234.
- Write timer count 0xFFFF_FFFE, then write ctrl 1, then read count after 5 idle cycles -> value has wrapped through 0 and equals the cycle-accurate expected value. Load during run=1 yields the written value, not value+1.
- Read 0x5000_0000 -> `data2CPU`=0, `MIO_ready` in cycle 1. A write to the same address leaves all state unchanged.
- Assert `reset` in cycle 2 of a RAM read -> `MIO_ready` never pulses, all outputs return to reset values next cycle. A re-issued read completes normally.
- RAM_WAIT=1 build, back-to-back reads with `req` held high -> completions every 3 cycles, `MIO_ready` never high two cycles in a row.
